// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin using one full-subtractor cell, LSB first
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sa, sb, sd, sd_next;
  logic             br, bmsb;
  logic [CW-1:0]    cnt;
  logic             x, y, d, bo;

  assign x = sa[0];
  assign y = sb[0];

  always_comb begin
    d  = x ^ y ^ br;
    bo = (~x & y) | (~(x ^ y) & br);
  end

  // difference bits enter at the top so the LSB lands at bit 0 after WIDTH shifts
  assign sd_next = WIDTH'({d, sd} >> 1);

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sd    <= '0;
      br    <= 1'b0;
      bmsb  <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            bmsb  <= b[WIDTH-1];
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sd  <= sd_next;
          br  <= bo;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            // on this edge x is still the original a[MSB]
            diff  <= sd_next;
            bout  <= bo;
            ovf   <= (x != bmsb) && (d != x);
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor with random stimulus
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk, rst_n, start, bin;
  logic [W-1:0] a, b;
  logic         busy, done, bout, ovf;
  logic [W-1:0] diff;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  typedef struct {
    int           cyc;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic [W-1:0] last_d = '0;
  logic         last_bo = 1'b0;
  logic         last_ov = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int av, input int bv, input int bi, input int c);
    exp_t e;
    int   sv;
    e.cyc = c;
    e.d   = W'((av - bv - bi) & ((1 << W) - 1));
    e.bo  = (av < bv + bi);
    sv    = ((av >= (1 << (W - 1))) ? av - (1 << W) : av)
          - ((bv >= (1 << (W - 1))) ? bv - (1 << W) : bv) - bi;
    e.ov  = (sv < -(1 << (W - 1))) || (sv > (1 << (W - 1)) - 1);
    return e;
  endfunction

  // monitor: pops on every done pulse, otherwise checks results are held
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_outputs", {busy, done, diff, bout, ovf}, 0);
    end else begin
      if (busy && done) chk("busy_and_done", 1, 0);
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("diff", diff, e.d);
          chk("bout", bout, e.bo);
          chk("ovf", ovf, e.ov);
          last_d  = e.d;
          last_bo = e.bo;
          last_ov = e.ov;
        end
      end else begin
        chk("held_result", {diff, bout, ovf}, {last_d, last_bo, last_ov});
      end
    end
  end

  // drive start with operands; returns after the accepting edge with c0 set
  task automatic issue(input int av, input int bv, input int bi, output int c0);
    @(posedge clk); #1;
    start = 1'b1; a = W'(av); b = W'(bv); bin = bi[0];
    @(posedge clk); #1;
    c0 = cyc;
    q.push_back(model(av, bv, bi, c0 + W));
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = $urandom_range(0, 1);
  endtask

  task automatic op(input int av, input int bv, input int bi);
    int c0;
    issue(av, bv, bi, c0);
    repeat (W + 1) @(posedge clk);
  endtask

  initial begin
    int c0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #1;
    chk("reset_state", {busy, done, diff, bout, ovf}, 0);
    #11 rst_n = 1'b1;

    op(8'h5A, 8'h3C, 0);
    op(8'h00, 8'h01, 0);
    op(8'h80, 8'h01, 0);
    op(8'h10, 8'h0F, 1);
    op(8'hFF, 8'hFF, 1);
    op(8'h00, 8'h00, 0);

    // starts during busy and during DONE must be ignored; operands churn every cycle
    issue(8'h5A, 8'h3C, 0, c0);
    for (int k = 1; k <= W + 1; k++) begin
      @(posedge clk); #1;
      a = W'($urandom); b = W'($urandom); bin = $urandom_range(0, 1);
      start = (k == 3) || (k == W);
      if (k == 3) begin a = 8'hFF; b = 8'h00; end
    end
    start = 1'b0;
    repeat (3) @(posedge clk);

    // start held high: one result every W+2 cycles
    @(posedge clk); #1;
    start = 1'b1; a = 8'h5A; b = 8'h3C; bin = 1'b0;
    @(posedge clk); #1;
    c0 = cyc;
    for (int k = 0; k < 3; k++) q.push_back(model(8'h5A, 8'h3C, 0, c0 + k * (W + 2) + W));
    repeat (2 * (W + 2)) @(posedge clk);
    #1 start = 1'b0;
    repeat (W + 1) @(posedge clk);

    // asynchronous reset mid-operation
    issue(8'h33, 8'h11, 0, c0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    last_d = '0; last_bo = 1'b0; last_ov = 1'b0;
    #1;
    chk("async_reset", {busy, done, diff, bout, ovf}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (W + 4) @(posedge clk);
    op(8'h5A, 8'h3C, 0);

    for (int i = 0; i < 20; i++)
      op($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));

    repeat (4) @(posedge clk);
    chk("pending_results", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
